// File: rtl/systolic_exp_stream_fx.sv
// Pipelined fixed-point Taylor-series exp array for the softmax datapath.
// N rows advance in lockstep; one global enable stalls every stage together.
module systolic_exp_stream_fx #(
   parameter int N    = 4,
   parameter int K    = 4,
   parameter int W    = 16,
   parameter int FRAC = 8,
   localparam int SW  = W + $clog2(N)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N*W-1:0]  data_in,
   input  logic            sub_max,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [N*W-1:0]  exp_out,
   output logic [SW-1:0]   exp_sum_out,
   output logic            out_sat
);

   // W*K bits hold every pow*x and pow*INVF product exactly for |x| < 2^(W-1).
   localparam int PW = W * K;
   localparam logic signed [PW-1:0] ONE  = {{(PW-1){1'b0}}, 1'b1} << FRAC;
   localparam logic signed [PW-1:0] EMAX = {{(PW-W){1'b0}}, {W{1'b1}}};
   localparam logic signed [W-1:0]  XMIN = {1'b1, {(W-1){1'b0}}};

   function automatic logic signed [PW-1:0] invf(input int j);
      longint f;
      f = 1;
      for (int t = 2; t <= j; t++) f = f * longint'(t);
      return PW'(((longint'(1) << FRAC) + f / 2) / f);
   endfunction

   logic                 en;
   logic                 va;
   logic [K-1:0]         vld;

   logic signed [W-1:0]  in_max;
   logic signed [W-1:0]  xa_r [N];
   logic signed [W-1:0]  ma_r;
   logic                 sa_r;

   logic signed [W-1:0]  x0_nxt [N];
   logic signed [W:0]    diff;

   logic signed [W-1:0]  x_r   [K-1][N];
   logic signed [PW-1:0] pow_r [K-1][N];
   logic signed [PW-1:0] acc_r [K][N];
   logic signed [PW-1:0] pow_nxt [K-1][N];
   logic signed [PW-1:0] acc_nxt [K-1][N];
   logic signed [PW-1:0] xe;

   logic [N*W-1:0]       exp_nxt;
   logic [SW-1:0]        sum_nxt;
   logic                 sat_nxt;

   assign en       = !out_valid || out_ready;
   assign in_ready = en;

   always_comb begin
      in_max = data_in[W-1:0];
      for (int i = 1; i < N; i++) begin
         if ($signed(data_in[i*W +: W]) > in_max) in_max = data_in[i*W +: W];
      end
   end

   // Max subtraction is done one bit wider; the result is never positive, so only the low side clamps.
   always_comb begin
      diff = '0;
      for (int i = 0; i < N; i++) begin
         x0_nxt[i] = xa_r[i];
         if (sa_r) begin
            diff = $signed({xa_r[i][W-1], xa_r[i]}) - $signed({ma_r[W-1], ma_r});
            x0_nxt[i] = (diff[W] != diff[W-1]) ? XMIN : diff[W-1:0];
         end
      end
   end

   always_comb begin
      xe = '0;
      for (int j = 1; j < K; j++) begin
         for (int i = 0; i < N; i++) begin
            xe = {{(PW-W){x_r[j-1][i][W-1]}}, x_r[j-1][i]};
            pow_nxt[j-1][i] = (pow_r[j-1][i] * xe) >>> FRAC;
            acc_nxt[j-1][i] = acc_r[j-1][i] + ((pow_nxt[j-1][i] * invf(j)) >>> FRAC);
         end
      end
   end

   always_comb begin
      exp_nxt = '0;
      sum_nxt = '0;
      sat_nxt = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (acc_r[K-1][i] < 0) begin
            exp_nxt[i*W +: W] = '0;
            sat_nxt = 1'b1;
         end else if (acc_r[K-1][i] > EMAX) begin
            exp_nxt[i*W +: W] = '1;
            sat_nxt = 1'b1;
         end else begin
            exp_nxt[i*W +: W] = acc_r[K-1][i][W-1:0];
         end
         sum_nxt = sum_nxt + SW'(exp_nxt[i*W +: W]);
      end
   end

   // Datapath registers carry no reset; only the valid bits decide what is live.
   always_ff @(posedge clk) begin
      if (en) begin
         ma_r <= in_max;
         sa_r <= sub_max;
         for (int i = 0; i < N; i++) begin
            xa_r[i]     <= data_in[i*W +: W];
            x_r[0][i]   <= x0_nxt[i];
            pow_r[0][i] <= ONE;
            acc_r[0][i] <= ONE;
            for (int j = 1; j < K; j++) acc_r[j][i] <= acc_nxt[j-1][i];
            for (int j = 1; j < K-1; j++) begin
               x_r[j][i]   <= x_r[j-1][i];
               pow_r[j][i] <= pow_nxt[j-1][i];
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         va          <= 1'b0;
         vld         <= '0;
         out_valid   <= 1'b0;
         exp_out     <= '0;
         exp_sum_out <= '0;
         out_sat     <= 1'b0;
      end else if (en) begin
         va        <= in_valid;
         vld       <= {vld[K-2:0], va};
         out_valid <= vld[K-1];
         if (vld[K-1]) begin
            exp_out     <= exp_nxt;
            exp_sum_out <= sum_nxt;
            out_sat     <= sat_nxt;
         end
      end
   end

endmodule

// File: tb/tb_systolic_exp_stream_fx.sv
// Bench for systolic_exp_stream_fx: directed vectors, random backpressure
// against a plain-arithmetic exp model, and asynchronous reset mid-stream.
module tb_systolic_exp_stream_fx;

   localparam int N    = 4;
   localparam int K    = 4;
   localparam int W    = 16;
   localparam int FRAC = 8;
   localparam int SW   = W + $clog2(N);

   typedef struct packed {
      logic [N*W-1:0] e;
      logic [SW-1:0]  s;
      logic           sat;
   } res_t;

   logic           clk;
   logic           reset;
   logic           in_valid;
   logic           in_ready;
   logic [N*W-1:0] data_in;
   logic           sub_max;
   logic           out_valid;
   logic           out_ready;
   logic [N*W-1:0] exp_out;
   logic [SW-1:0]  exp_sum_out;
   logic           out_sat;

   int compared   = 0;
   int mismatched = 0;

   res_t sb[$];

   systolic_exp_stream_fx #(.N(N), .K(K), .W(W), .FRAC(FRAC)) dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .data_in    (data_in),
      .sub_max    (sub_max),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .exp_out    (exp_out),
      .exp_sum_out(exp_sum_out),
      .out_sat    (out_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      compared++;
      assert (obs === expv) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, expv);
      end
   endtask

   // Floor division by 2^FRAC written without shifts.
   function automatic longint fdiv(input longint a);
      longint dv;
      dv = longint'(1) << FRAC;
      return (a >= 0) ? a / dv : -((-a + dv - 1) / dv);
   endfunction

   function automatic longint invf_tb(input int j);
      longint f;
      f = 1;
      for (int t = 2; t <= j; t++) f = f * longint'(t);
      return ((longint'(1) << (FRAC + 1)) + f) / (2 * f);
   endfunction

   function automatic res_t model(input logic [N*W-1:0] d, input logic sm);
      res_t   r;
      longint x [N];
      longint mx, pw, ac, e, lo, hi;
      r  = '0;
      lo = -(longint'(1) << (W-1));
      hi = (longint'(1) << W) - 1;
      for (int i = 0; i < N; i++) x[i] = longint'($signed(d[i*W +: W]));
      if (sm) begin
         mx = x[0];
         for (int i = 1; i < N; i++) if (x[i] > mx) mx = x[i];
         for (int i = 0; i < N; i++) begin
            x[i] = x[i] - mx;
            if (x[i] < lo) x[i] = lo;
         end
      end
      for (int i = 0; i < N; i++) begin
         pw = longint'(1) << FRAC;
         ac = pw;
         for (int j = 1; j < K; j++) begin
            pw = fdiv(pw * x[i]);
            ac = ac + fdiv(pw * invf_tb(j));
         end
         if (ac < 0) begin
            e = 0;
            r.sat = 1'b1;
         end else if (ac > hi) begin
            e = hi;
            r.sat = 1'b1;
         end else begin
            e = ac;
         end
         r.e[i*W +: W] = W'(e);
         r.s = r.s + SW'(e);
      end
      return r;
   endfunction

   function automatic logic [N*W-1:0] pack(input int a, input int b, input int c, input int d);
      return {W'(d), W'(c), W'(b), W'(a)};
   endfunction

   function automatic logic [N*W-1:0] rand_vec();
      logic [N*W-1:0] v;
      for (int i = 0; i < N; i++) begin
         if ($urandom_range(7, 0) == 0) v[i*W +: W] = W'($urandom);
         else v[i*W +: W] = W'(int'($urandom_range(2047, 0)) - 1024);
      end
      return v;
   endfunction

   // Sends one vector into an empty pipe and checks latency and result.
   task automatic apply_stimulus(input string tag, input logic [N*W-1:0] d, input logic sm,
                                 input logic [N*W-1:0] ee, input int es, input logic esat);
      int lat;
      @(negedge clk);
      in_valid  = 1'b1;
      data_in   = d;
      sub_max   = sm;
      out_ready = 1'b1;
      #1;
      check_output({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check_output({tag, "_latency"}, 64'(lat), 64'(K + 1));
      check_output({tag, "_exp"}, exp_out, ee);
      check_output({tag, "_sum"}, 64'(exp_sum_out), 64'(es));
      check_output({tag, "_sat"}, 64'(out_sat), 64'(esat));
      @(posedge clk);
      #1;
      check_output({tag, "_drained"}, 64'(out_valid), 64'd0);
   endtask

   initial begin
      res_t  exp_r;
      res_t  held;
      logic  stalled;
      logic  acc_prev;
      int    sent, got, cyc, seen;

      reset     = 1'b1;
      in_valid  = 1'b0;
      data_in   = '0;
      sub_max   = 1'b0;
      out_ready = 1'b0;
      #12;
      check_output("rst_out_valid", 64'(out_valid), 64'd0);
      check_output("rst_exp", exp_out, 64'd0);
      check_output("rst_sum", 64'(exp_sum_out), 64'd0);
      check_output("rst_sat", 64'(out_sat), 64'd0);
      check_output("rst_in_ready", 64'(in_ready), 64'd1);
      @(negedge clk);
      reset = 1'b0;

      apply_stimulus("zeros", pack(0, 0, 0, 0), 1'b0, pack(256, 256, 256, 256), 1024, 1'b0);
      apply_stimulus("pm_one", pack(256, -256, 0, 0), 1'b0, pack(683, 85, 256, 256), 1280, 1'b0);
      apply_stimulus("submax", pack(256, 0, 0, 0), 1'b1, pack(256, 85, 85, 85), 511, 1'b0);
      apply_stimulus("sat", pack(32767, -2048, 0, 0), 1'b0, pack(65535, 0, 256, 256), 66047, 1'b1);
      apply_stimulus("sub_clamp", pack(32767, -32768, -1, -1), 1'b1, pack(256, 0, 0, 0), 256, 1'b1);

      sent = 0; got = 0; cyc = 0; stalled = 1'b0; acc_prev = 1'b1; held = '0;
      while (got < 8 && cyc < 300) begin
         @(negedge clk);
         cyc++;
         if (acc_prev) begin
            data_in = rand_vec();
            sub_max = 1'($urandom_range(1, 0));
         end
         in_valid  = (sent < 8);
         out_ready = ($urandom_range(2, 0) != 0);
         #1;
         if (stalled) begin
            check_output("bp_hold_valid", 64'(out_valid), 64'd1);
            check_output("bp_hold_exp", exp_out, held.e);
            check_output("bp_hold_sum", 64'(exp_sum_out), 64'(held.s));
         end
         stalled = 1'b0;
         if (out_valid) begin
            check_output("bp_in_ready", 64'(in_ready), 64'(out_ready));
            if (out_ready) begin
               if (sb.size() == 0) begin
                  check_output("bp_extra_output", 64'(sb.size()), 64'd1);
               end else begin
                  exp_r = sb.pop_front();
                  check_output("bp_exp", exp_out, exp_r.e);
                  check_output("bp_sum", 64'(exp_sum_out), 64'(exp_r.s));
                  check_output("bp_sat", 64'(out_sat), 64'(exp_r.sat));
               end
               got++;
            end else begin
               held    = '{e: exp_out, s: exp_sum_out, sat: out_sat};
               stalled = 1'b1;
            end
         end
         acc_prev = in_valid && in_ready;
         if (acc_prev) begin
            sb.push_back(model(data_in, sub_max));
            sent++;
         end
      end
      check_output("bp_count", 64'(got), 64'd8);
      check_output("bp_queue_empty", 64'(sb.size()), 64'd0);

      @(negedge clk);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      sub_max   = 1'b0;
      repeat (6) begin
         data_in = rand_vec();
         @(posedge clk);
         #1;
      end
      check_output("rs_pre_valid", 64'(out_valid), 64'd1);
      #2;
      reset    = 1'b1;
      in_valid = 1'b0;
      #1;
      check_output("rs_out_valid", 64'(out_valid), 64'd0);
      check_output("rs_exp", exp_out, 64'd0);
      check_output("rs_sum", 64'(exp_sum_out), 64'd0);
      check_output("rs_sat", 64'(out_sat), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      seen = 0;
      repeat (20) begin
         @(posedge clk);
         #1;
         if (out_valid) seen++;
      end
      check_output("rs_no_stale", 64'(seen), 64'd0);
      check_output("rs_in_ready", 64'(in_ready), 64'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
